lbist_scan_target: RTL and testbench
====================================

Name: lbist_scan_target

Overview:
- Scan-side test target for the LBIST controller: SCW parallel scan chains of programmable length.
- Models the device under test on the other end of the scan interface:
  - shifts `scan_in` to `scan_out` while `scan_en`=1;
  - captures a fixed deterministic "functional" response while `scan_en`=0.
- Also monitors the scan protocol: counts shift bursts and captures, and flags sticky protocol errors.
- Used as the on-chip/loopback LBIST self-check target and as the bench reference for the controller.

Parameters:
- SCW, 8, scan chain width (number of parallel chains)
- DEPTH, 64, physical flops per chain (maximum chain length)
- DW, 16, width of the length/count configuration and counters

Ports:
- mclk  in  1  master clock; the scan clock is the gated mclk
- rst_n  in  1  reset; asynchronous, active-low
- srst  in  1  synchronous software reset
- scan_clk_en  in  1  scan clock gate enable; the block advances only when 1
- scan_rst_n  in  1  scan reset, sampled on mclk
- scan_mode  in  1  scan mode enable
- scan_en  in  1  1 = shift, 0 = capture
- scan_in  in  SCW  serial data in, one bit per chain
- scan_out  out  SCW  serial data out, one bit per chain
- cfg_chain_len  in  DW  active chain length, 1..DEPTH
- cfg_shift_len  in  DW  expected clocks per shift burst
- shift_burst_cnt  out  DW  completed shift bursts
- capture_cnt  out  DW  completed captures
- err_shift_len  out  1  sticky: shift burst length != cfg_shift_len
- err_capture  out  1  sticky: capture pulse longer than 1 cycle
- err_reset_clk  out  1  sticky: scan clock while scan_rst_n=0, or while scan_mode=0
- busy  out  1  monitor state != OFF

Behaviour:
- Reset (rst_n=0, or srst=1 on a clock edge) clears:
  - all chain flops, state -> OFF, all counters and error flags.
  - All outputs are 0 in reset.
- Effective length: L = clamp(cfg_chain_len, 1, DEPTH). Values 0 and >DEPTH map to 1 and DEPTH respectively.
- Combinational output: scan_out[c] = chain[c][L-1]. No pipeline; valid in the same cycle.
- Chain update, clock-enabled by scan_clk_en & scan_mode. Priority, highest first:
  - scan_rst_n=0: all chain flops <= 0.
  - scan_en=1 (shift): chain[c] <= {chain[c][DEPTH-2:0], scan_in[c]}. Bits at index >= L also shift, but are unobservable.
  - scan_en=0 (capture): for every i, chain[c][i] <= chain[c][i] ^ chain[(c+1) mod SCW][i] ^ (i==0).
    - The right-hand side uses pre-update values (parallel load).
- Chain flops hold whenever scan_clk_en=0 or scan_mode=0.
- Monitor FSM; states OFF, RST, IDLE, SHIFT, CAPT, evaluated every mclk:
  - OFF: scan_mode=1 -> RST if scan_rst_n=0, else IDLE.
  - Any state: scan_mode=0 -> OFF. Counters and flags hold.
  - scan_rst_n=0 -> RST (overrides everything except OFF).
  - RST: scan_rst_n=1 -> IDLE.
  - IDLE:
    - scan_clk_en & scan_en -> SHIFT, run counter = 1.
    - scan_clk_en & !scan_en -> CAPT.
  - SHIFT:
    - scan_clk_en & scan_en: run counter +1, saturating at all-ones.
    - scan_clk_en=0: burst ends. shift_burst_cnt +1. If run counter != cfg_shift_len, set err_shift_len. -> IDLE.
    - scan_clk_en & !scan_en: same burst-end bookkeeping, then -> CAPT. No idle gap between shift and capture is legal.
  - CAPT:
    - On entry: capture_cnt +1.
    - scan_clk_en=1 on the following cycle sets err_capture; the FSM stays in CAPT and the capture is not re-counted.
    - scan_clk_en=0 -> IDLE.
- err_reset_clk set when scan_clk_en=1 while scan_rst_n=0 or scan_mode=0.
- Counter rules:
  - shift_burst_cnt and capture_cnt wrap modulo 2^DW.
  - Error flags clear only on reset or srst.
- Simultaneous events: srst wins over everything; scan_rst_n wins over shift/capture.
- Reset mid-burst: the burst is discarded and not counted.

Decomposition:
- Package lbist_pkg:
  - monitor state enum (OFF, RST, IDLE, SHIFT, CAPT), 3 bits;
  - default DW constant.
- Sub-module lbist_scan_chain, one instance per chain (generate loop):
  - DEPTH flops with shift/capture/clear;
  - length-mux output;
  - capture neighbour vector as an input.
- Monitor FSM, counters and error flags live in the top.

Test Plan:
- Reset values: rst_n low -> all outputs 0 and busy=0. Raise scan_mode=1 -> busy=1.
- Shift-through:
  - Setup: L=4, cfg_shift_len=4, scan_en=1, 4 enabled clocks with scan_in=8'hA5,5A,FF,00.
  - Required: scan_out shows 8'hA5 on the cycle after the 4th clock; shift_burst_cnt=1; no errors.
- Capture:
  - Setup: preload chain[0..7] all zeros, then one capture clock.
  - Required: bit 0 of every chain = 1, other bits 0. A shift of L=4 returns 8'hFF on the last clock. capture_cnt=1.
- Length mismatch: cfg_shift_len=5, burst of 4 -> err_shift_len=1, sticky across the next correct burst. srst clears it.
- Protocol violations:
  - 2-cycle capture pulse -> err_capture=1 and capture_cnt=1.
  - scan_clk_en pulsed while scan_rst_n=0 -> err_reset_clk=1 and chain stays 0.
- Loopback with controller:
  - Setup: cfg_chain_depth=7, pattern count 3; cfg_chain_len=8, cfg_shift_len=8.
  - Required: shift_burst_cnt=4, capture_cnt=3, no errors, lbist_done=1. Controller signature matches the bench model of this block.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared types and defaults for the LBIST scan-side target.
// Monitor state encoding and the default configuration/counter width.
package lbist_pkg;

  localparam int DEFAULT_DW = 16;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_RST   = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CAPT  = 3'd4
  } mon_state_e;

endpackage

// File: rtl/lbist_scan_chain.sv
// One physical scan chain: shift, XOR-with-neighbour capture, scan reset.
// The serial output is tapped at the programmed length through a mux.
module lbist_scan_chain #(
  parameter int DEPTH = 64,
  parameter int LIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             adv,
  input  logic             scan_rst_n,
  input  logic             scan_en,
  input  logic             scan_in,
  input  logic [DEPTH-1:0] nbr,
  input  logic [LIW-1:0]   len_sel,
  output logic [DEPTH-1:0] bits,
  output logic             scan_out
);

  // NOTE: the chain flops are reset explicitly, unlike a RAM, because scan_out
  // must read 0 straight out of reset; sequential state uses <= only so every
  // chain samples its neighbour's pre-edge value during capture.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (srst) begin
      bits <= '0;
    end else if (adv) begin
      if (!scan_rst_n) begin
        bits <= '0;
      end else if (scan_en) begin
        bits <= {bits[DEPTH-2:0], scan_in};
      end else begin
        bits <= bits ^ nbr ^ DEPTH'(1);
      end
    end
  end

  assign scan_out = bits[len_sel];

endmodule

// File: rtl/lbist_scan_target.sv
// Scan-side LBIST test target: SCW parallel programmable-length chains
// plus a protocol monitor counting shift bursts/captures and flagging errors.
module lbist_scan_target
  import lbist_pkg::*;
#(
  parameter int SCW   = 8,
  parameter int DEPTH = 64,
  parameter int DW    = DEFAULT_DW
) (
  input  logic          mclk,
  input  logic          rst_n,
  input  logic          srst,
  input  logic          scan_clk_en,
  input  logic          scan_rst_n,
  input  logic          scan_mode,
  input  logic          scan_en,
  input  logic [SCW-1:0] scan_in,
  output logic [SCW-1:0] scan_out,
  input  logic [DW-1:0] cfg_chain_len,
  input  logic [DW-1:0] cfg_shift_len,
  output logic [DW-1:0] shift_burst_cnt,
  output logic [DW-1:0] capture_cnt,
  output logic          err_shift_len,
  output logic          err_capture,
  output logic          err_reset_clk,
  output logic          busy
);

  localparam int LIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LIW-1:0]   len_sel;
  logic [DEPTH-1:0] chain_bits [SCW];
  logic             adv;

  mon_state_e state_q, state_d;
  logic [DW-1:0] run_cnt;
  logic run_start, run_inc, burst_end, capt_entry, capt_again, clk_violation;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    len_sel = LIW'(DEPTH - 1);
    if (cfg_chain_len == '0) begin
      len_sel = '0;
    end else if (cfg_chain_len < DW'(DEPTH)) begin
      len_sel = LIW'(cfg_chain_len - DW'(1));
    end
  end

  assign adv = scan_clk_en & scan_mode;

  for (genvar c = 0; c < SCW; c++) begin : g_chain
    lbist_scan_chain #(
      .DEPTH(DEPTH),
      .LIW  (LIW)
    ) u_chain (
      .mclk      (mclk),
      .rst_n     (rst_n),
      .srst      (srst),
      .adv       (adv),
      .scan_rst_n(scan_rst_n),
      .scan_en   (scan_en),
      .scan_in   (scan_in[c]),
      .nbr       (chain_bits[(c + 1) % SCW]),
      .len_sel   (len_sel),
      .bits      (chain_bits[c]),
      .scan_out  (scan_out[c])
    );
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
    end else if (srst) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving scan mode or asserting scan reset mid-burst discards the burst.
  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    run_inc   = 1'b0;
    burst_end = 1'b0;
    if (!scan_mode) begin
      state_d = ST_OFF;
    end else if (!scan_rst_n) begin
      state_d = ST_RST;
    end else begin
      unique case (state_q)
        ST_OFF, ST_RST: state_d = ST_IDLE;
        ST_IDLE: begin
          if (scan_clk_en) begin
            state_d   = scan_en ? ST_SHIFT : ST_CAPT;
            run_start = scan_en;
          end
        end
        ST_SHIFT: begin
          if (!scan_clk_en) begin
            burst_end = 1'b1;
            state_d   = ST_IDLE;
          end else if (!scan_en) begin
            burst_end = 1'b1;
            state_d   = ST_CAPT;
          end else begin
            run_inc = 1'b1;
          end
        end
        ST_CAPT: begin
          if (!scan_clk_en) state_d = ST_IDLE;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign capt_entry    = (state_d == ST_CAPT) && (state_q != ST_CAPT);
  assign capt_again    = scan_mode && scan_rst_n && (state_q == ST_CAPT) && scan_clk_en;
  assign clk_violation = scan_clk_en && (!scan_rst_n || !scan_mode);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt         <= '0;
      shift_burst_cnt <= '0;
      capture_cnt     <= '0;
      err_shift_len   <= 1'b0;
      err_capture     <= 1'b0;
      err_reset_clk   <= 1'b0;
    end else if (srst) begin
      run_cnt         <= '0;
      shift_burst_cnt <= '0;
      capture_cnt     <= '0;
      err_shift_len   <= 1'b0;
      err_capture     <= 1'b0;
      err_reset_clk   <= 1'b0;
    end else begin
      if (run_start) begin
        run_cnt <= DW'(1);
      end else if (run_inc && (run_cnt != '1)) begin
        run_cnt <= run_cnt + DW'(1);
      end
      if (burst_end) begin
        shift_burst_cnt <= shift_burst_cnt + DW'(1);
        if (run_cnt != cfg_shift_len) err_shift_len <= 1'b1;
      end
      if (capt_entry)    capture_cnt   <= capture_cnt + DW'(1);
      if (capt_again)    err_capture   <= 1'b1;
      if (clk_violation) err_reset_clk <= 1'b1;
    end
  end

  assign busy = (state_q != ST_OFF);

endmodule

// File: tb/tb_lbist_scan_target.sv
// Self-checking bench for lbist_scan_target: directed scenarios plus random
// shift/capture traffic compared against an array-based chain model.
module tb_lbist_scan_target;

  localparam int SCW   = 8;
  localparam int DEPTH = 64;
  localparam int DW    = 16;

  logic           mclk = 1'b0;
  logic           rst_n, srst, scan_clk_en, scan_rst_n, scan_mode, scan_en;
  logic [SCW-1:0] scan_in, scan_out;
  logic [DW-1:0]  cfg_chain_len, cfg_shift_len, shift_burst_cnt, capture_cnt;
  logic           err_shift_len, err_capture, err_reset_clk, busy;

  int checks = 0;
  int errors = 0;

  bit mdl [SCW][DEPTH];

  always #5 mclk = ~mclk;

  lbist_scan_target #(.SCW(SCW), .DEPTH(DEPTH), .DW(DW)) dut (
    .mclk           (mclk),
    .rst_n          (rst_n),
    .srst           (srst),
    .scan_clk_en    (scan_clk_en),
    .scan_rst_n     (scan_rst_n),
    .scan_mode      (scan_mode),
    .scan_en        (scan_en),
    .scan_in        (scan_in),
    .scan_out       (scan_out),
    .cfg_chain_len  (cfg_chain_len),
    .cfg_shift_len  (cfg_shift_len),
    .shift_burst_cnt(shift_burst_cnt),
    .capture_cnt    (capture_cnt),
    .err_shift_len  (err_shift_len),
    .err_capture    (err_capture),
    .err_reset_clk  (err_reset_clk),
    .busy           (busy)
  );

  function automatic int eff_len(input logic [DW-1:0] v);
    if (v == 0) return 1;
    if (int'(v) > DEPTH) return DEPTH;
    return int'(v);
  endfunction

  function automatic logic [SCW-1:0] mdl_out();
    logic [SCW-1:0] r;
    int l;
    l = eff_len(cfg_chain_len);
    for (int c = 0; c < SCW; c++) r[c] = mdl[c][l-1];
    return r;
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] s, input logic [SCW-1:0] d);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ {24'h0, d};
  endfunction

  task automatic clear_model();
    for (int c = 0; c < SCW; c++)
      for (int i = 0; i < DEPTH; i++) mdl[c][i] = 1'b0;
  endtask

  // One clock edge; the model applies the chain rules to the inputs held at the edge.
  task automatic tick();
    bit old [SCW][DEPTH];
    @(posedge mclk);
    if (srst) begin
      clear_model();
    end else if (scan_clk_en && scan_mode) begin
      if (!scan_rst_n) begin
        clear_model();
      end else if (scan_en) begin
        for (int c = 0; c < SCW; c++) begin
          for (int i = DEPTH - 1; i > 0; i--) mdl[c][i] = mdl[c][i-1];
          mdl[c][0] = scan_in[c];
        end
      end else begin
        old = mdl;
        for (int c = 0; c < SCW; c++)
          for (int i = 0; i < DEPTH; i++)
            mdl[c][i] = old[c][i] ^ old[(c + 1) % SCW][i] ^ (i == 0);
      end
    end
    #1;
  endtask

  task automatic cyc(input logic en, input logic sen, input logic [SCW-1:0] din);
    scan_clk_en = en;
    scan_en     = sen;
    scan_in     = din;
    tick();
  endtask

  task automatic do_srst();
    srst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    srst = 1'b0;
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; srst = 1'b0; scan_mode = 1'b1; scan_rst_n = 1'b1;
    scan_clk_en = 1'b0; scan_en = 1'b0; scan_in = 8'h3C;
    cfg_chain_len = 16'd4; cfg_shift_len = 16'd4;
    clear_model();
    repeat (2) @(posedge mclk);
    #1;
    checks++;
    if (scan_out !== 8'h00) begin errors++; $display("FAIL reset_scan_out got %h exp 00", scan_out); end
    checks++;
    if (shift_burst_cnt !== 16'd0 || capture_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", shift_burst_cnt, capture_cnt);
    end
    checks++;
    if ({err_shift_len, err_capture, err_reset_clk} !== 3'b000) begin
      errors++; $display("FAIL reset_errs got %b exp 000", {err_shift_len, err_capture, err_reset_clk});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    scan_mode = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL off_busy got %b exp 0", busy); end
    scan_mode = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mode_busy got %b exp 1", busy); end
  endtask

  task automatic test_shift_through();
    cfg_chain_len = 16'd4; cfg_shift_len = 16'd4;
    cyc(1'b1, 1'b1, 8'hA5);
    cyc(1'b1, 1'b1, 8'h5A);
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'h00);
    checks++;
    if (scan_out !== 8'hA5) begin errors++; $display("FAIL shift_through_out got %h exp a5", scan_out); end
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (shift_burst_cnt !== 16'd1 || capture_cnt !== 16'd0) begin
      errors++; $display("FAIL shift_through_cnt got %0d/%0d exp 1/0", shift_burst_cnt, capture_cnt);
    end
    checks++;
    if ({err_shift_len, err_capture, err_reset_clk} !== 3'b000) begin
      errors++; $display("FAIL shift_through_errs got %b exp 000", {err_shift_len, err_capture, err_reset_clk});
    end
  endtask

  task automatic test_capture();
    do_srst();
    cfg_chain_len = 16'd4; cfg_shift_len = 16'd4;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (capture_cnt !== 16'd1) begin errors++; $display("FAIL capture_cnt got %0d exp 1", capture_cnt); end
    checks++;
    if (scan_out !== 8'h00) begin errors++; $display("FAIL capture_bit3 got %h exp 00", scan_out); end
    cfg_chain_len = 16'd1;
    #1;
    checks++;
    if (scan_out !== 8'hFF) begin errors++; $display("FAIL capture_bit0 got %h exp ff", scan_out); end
    cfg_chain_len = 16'd4;
    repeat (3) cyc(1'b1, 1'b1, '0);
    checks++;
    if (scan_out !== 8'hFF) begin errors++; $display("FAIL capture_unload got %h exp ff", scan_out); end
    cyc(1'b1, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (shift_burst_cnt !== 16'd1 || err_shift_len !== 1'b0) begin
      errors++; $display("FAIL capture_unload_burst got %0d/%b exp 1/0", shift_burst_cnt, err_shift_len);
    end
  endtask

  task automatic test_len_mismatch();
    do_srst();
    cfg_chain_len = 16'd4; cfg_shift_len = 16'd5;
    repeat (4) cyc(1'b1, 1'b1, 8'($urandom));
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (err_shift_len !== 1'b1 || shift_burst_cnt !== 16'd1) begin
      errors++; $display("FAIL mismatch_set got %b/%0d exp 1/1", err_shift_len, shift_burst_cnt);
    end
    cfg_shift_len = 16'd4;
    repeat (4) cyc(1'b1, 1'b1, 8'($urandom));
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (err_shift_len !== 1'b1 || shift_burst_cnt !== 16'd2) begin
      errors++; $display("FAIL mismatch_sticky got %b/%0d exp 1/2", err_shift_len, shift_burst_cnt);
    end
    do_srst();
    checks++;
    if (err_shift_len !== 1'b0 || shift_burst_cnt !== 16'd0) begin
      errors++; $display("FAIL mismatch_srst got %b/%0d exp 0/0", err_shift_len, shift_burst_cnt);
    end
  endtask

  task automatic test_protocol();
    do_srst();
    cfg_chain_len = 16'd1;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (err_capture !== 1'b1 || capture_cnt !== 16'd1) begin
      errors++; $display("FAIL long_capture got %b/%0d exp 1/1", err_capture, capture_cnt);
    end
    do_srst();
    scan_rst_n = 1'b0;
    cyc(1'b0, 1'b1, 8'hFF);
    checks++;
    if (busy !== 1'b1 || err_reset_clk !== 1'b0) begin
      errors++; $display("FAIL rst_state got %b/%b exp 1/0", busy, err_reset_clk);
    end
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (err_reset_clk !== 1'b1 || scan_out !== 8'h00) begin
      errors++; $display("FAIL clk_in_reset got %b/%h exp 1/00", err_reset_clk, scan_out);
    end
    scan_rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0);
    do_srst();
    cfg_shift_len = 16'd3;
    repeat (3) cyc(1'b1, 1'b1, 8'($urandom));
    scan_rst_n = 1'b0;
    cyc(1'b0, 1'b0, '0);
    scan_rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0);
    checks++;
    if (shift_burst_cnt !== 16'd0 || err_shift_len !== 1'b0 || mdl_out() !== scan_out) begin
      errors++; $display("FAIL burst_discard got %0d/%b exp 0/0", shift_burst_cnt, err_shift_len);
    end
  endtask

  task automatic test_len_clamp();
    logic [SCW-1:0] first, d;
    do_srst();
    cfg_chain_len = 16'd0;
    d = 8'($urandom);
    cyc(1'b1, 1'b1, d);
    checks++;
    if (scan_out !== d) begin errors++; $display("FAIL len_zero got %h exp %h", scan_out, d); end
    cfg_chain_len = 16'hFFFF;
    first = 8'($urandom);
    cyc(1'b1, 1'b1, first);
    for (int k = 1; k < DEPTH; k++) cyc(1'b1, 1'b1, 8'($urandom));
    checks++;
    if (scan_out !== first) begin errors++; $display("FAIL len_over got %h exp %h", scan_out, first); end
    cfg_chain_len = 16'(DEPTH);
    #1;
    checks++;
    if (scan_out !== first) begin errors++; $display("FAIL len_max got %h exp %h", scan_out, first); end
    cyc(1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    int n, exp_b, exp_c;
    logic exp_e;
    do_srst();
    exp_b = 0; exp_c = 0; exp_e = 1'b0;
    cfg_shift_len = 16'($urandom_range(1, 10));
    for (int op = 0; op < 60; op++) begin
      case ($urandom_range(0, 9))
        0:       cfg_chain_len = 16'd0;
        1:       cfg_chain_len = 16'($urandom_range(DEPTH + 1, 1000));
        default: cfg_chain_len = 16'($urandom_range(1, DEPTH));
      endcase
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        cyc(1'b1, 1'b1, 8'($urandom));
        checks++;
        if (scan_out !== mdl_out()) begin
          errors++; $display("FAIL rand_shift op %0d got %h exp %h", op, scan_out, mdl_out());
        end
      end
      exp_b++;
      if (n != int'(cfg_shift_len)) exp_e = 1'b1;
      case ($urandom_range(0, 2))
        0: begin
          cyc(1'b1, 1'b0, '0);
          exp_c++;
          cyc(1'b0, 1'b0, '0);
        end
        1: begin
          cyc(1'b0, 1'b0, '0);
          cyc(1'b1, 1'b0, '0);
          exp_c++;
          cyc(1'b0, 1'b0, '0);
        end
        default: cyc(1'b0, 1'b0, '0);
      endcase
      checks++;
      if (scan_out !== mdl_out()) begin
        errors++; $display("FAIL rand_post op %0d got %h exp %h", op, scan_out, mdl_out());
      end
    end
    checks++;
    if (int'(shift_burst_cnt) != exp_b || int'(capture_cnt) != exp_c) begin
      errors++; $display("FAIL rand_counts got %0d/%0d exp %0d/%0d", shift_burst_cnt, capture_cnt, exp_b, exp_c);
    end
    checks++;
    if ({err_shift_len, err_capture, err_reset_clk} !== {exp_e, 2'b00}) begin
      errors++; $display("FAIL rand_errs got %b exp %b", {err_shift_len, err_capture, err_reset_clk}, {exp_e, 2'b00});
    end
  endtask

  task automatic test_loopback();
    logic [31:0] sig_d, sig_m;
    do_srst();
    cfg_chain_len = 16'd8; cfg_shift_len = 16'd8;
    sig_d = '0; sig_m = '0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 8; k++) begin
        sig_d = fold(sig_d, scan_out);
        sig_m = fold(sig_m, mdl_out());
        cyc(1'b1, 1'b1, 8'($urandom));
      end
      if (p < 3) cyc(1'b1, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
    end
    checks++;
    if (shift_burst_cnt !== 16'd4 || capture_cnt !== 16'd3) begin
      errors++; $display("FAIL loop_counts got %0d/%0d exp 4/3", shift_burst_cnt, capture_cnt);
    end
    checks++;
    if ({err_shift_len, err_capture, err_reset_clk} !== 3'b000) begin
      errors++; $display("FAIL loop_errs got %b exp 000", {err_shift_len, err_capture, err_reset_clk});
    end
    checks++;
    if (sig_d !== sig_m) begin errors++; $display("FAIL loop_signature got %h exp %h", sig_d, sig_m); end
  endtask

  initial begin
    test_reset();
    test_shift_through();
    test_capture();
    test_len_mismatch();
    test_protocol();
    test_len_clamp();
    test_random();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
